// File: rtl/sccomp_run_ctrl.sv
// Run/step/breakpoint controller for the single-cycle CPU: gates the retire enable and
// reports halt cause plus the retired-instruction count.
module sccomp_run_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_HALT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_BP    = 2'b01;
    localparam logic [1:0] CAUSE_LIMIT = 2'b10;
    localparam logic [1:0] CAUSE_CMD   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             skip_bp_q, skip_bp_d;
    logic             done_q, done_d;

    logic cmd_acc;
    logic bp_hit;
    logic lim_hit;
    logic halt_req;
    logic clear_req;

    always_comb begin
        cmd_ready = (state_q != ST_STEP);
        cmd_acc   = cmd_valid && cmd_ready;
        bp_hit    = bp_en && (pc == bp_addr) && !skip_bp_q;
        lim_hit   = (cycle_limit != '0) && (cnt_q >= cycle_limit);
        halt_req  = cmd_valid && (cmd_op == OP_HALT);
        clear_req = cmd_acc && (cmd_op == OP_CLEAR);
    end

    // Retire gating is combinational so a halt condition suppresses the current instruction.
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            ST_RUN:  cpu_en = !bp_hit && !lim_hit && !halt_req;
            ST_STEP: cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        skip_bp_d = 1'b0;
        cnt_d     = (cpu_en && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d   = ST_RUN;
                            cause_d   = CAUSE_NONE;
                            // Lets a resume retire the instruction sitting on the breakpoint.
                            skip_bp_d = 1'b1;
                        end
                        OP_STEP: begin
                            state_d = ST_STEP;
                            cause_d = CAUSE_NONE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_CMD;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_CMD;
                end else if (bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if (lim_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_LIMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cause_d = CAUSE_NONE;
        end

        done_d = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cause_q   <= CAUSE_NONE;
            skip_bp_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            skip_bp_q <= skip_bp_d;
            done_q    <= done_d;
        end
    end

    assign cycle_cnt  = cnt_q;
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// Self-checking bench for sccomp_run_ctrl: directed scenarios then random commands, all
// compared each cycle against a behavioural model of the run controller.
module tb_sccomp_run_ctrl;

    localparam int PC_W    = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    typedef enum int {MIdle, MRun, MStep, MHalt} mode_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_ready;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [CNT_W-1:0] cycle_limit;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic             halted;
    logic [1:0]       halt_cause;
    logic             done;

    sccomp_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .bp_en(bp_en), .bp_addr(bp_addr), .cycle_limit(cycle_limit),
        .pc(pc), .cpu_en(cpu_en), .cycle_cnt(cycle_cnt), .halted(halted),
        .halt_cause(halt_cause), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state (m_*) and its value after the coming edge (n_*).
    mode_t       m_mode, n_mode;
    int          m_cnt, n_cnt;
    logic [1:0]  m_cause, n_cause;
    logic        m_skip, n_skip;
    logic        m_done, n_done;
    logic [31:0] n_pc;

    logic        cfg_bp_en;
    logic [31:0] cfg_bp_addr;
    logic [15:0] cfg_limit;
    int          en_cnt;
    int          done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        n_mode  = MIdle;
        n_cnt   = 0;
        n_cause = 2'b00;
        n_skip  = 1'b0;
        n_done  = 1'b0;
        n_pc    = 32'h0;
    endtask

    task automatic commit();
        m_mode  = n_mode;
        m_cnt   = n_cnt;
        m_cause = n_cause;
        m_skip  = n_skip;
        m_done  = n_done;
        pc      = n_pc;
    endtask

    task automatic drive(input logic v, input logic [1:0] op);
        cmd_valid   = v;
        cmd_op      = op;
        bp_en       = cfg_bp_en;
        bp_addr     = cfg_bp_addr;
        cycle_limit = cfg_limit;
    endtask

    task automatic evaluate();
        logic bp, lim, hreq, rdy, acc, clr, en;
        bp   = bp_en && (pc == bp_addr) && !m_skip;
        lim  = (cycle_limit != 16'd0) && (m_cnt >= int'(cycle_limit));
        hreq = cmd_valid && (cmd_op == 2'd2);
        rdy  = (m_mode != MStep);
        acc  = cmd_valid && rdy;
        clr  = acc && (cmd_op == 2'd3);
        if (m_mode == MRun) en = !(bp || lim || hreq);
        else en = (m_mode == MStep);

        check_eq("cpu_en", 32'(cpu_en), 32'(en));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(rdy));
        check_eq("halted", 32'(halted), 32'(m_mode == MHalt));
        check_eq("halt_cause", 32'(halt_cause), 32'(m_cause));
        check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
        check_eq("done", 32'(done), 32'(m_done));
        en_cnt   += int'(cpu_en);
        done_cnt += int'(done);

        n_mode  = m_mode;
        n_cause = m_cause;
        n_skip  = 1'b0;
        n_cnt   = (en && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        n_pc    = en ? pc + 32'd4 : pc;
        case (m_mode)
            MIdle, MHalt: begin
                if (acc && cmd_op == 2'd0) begin
                    n_mode = MRun; n_cause = 2'b00; n_skip = 1'b1;
                end else if (acc && cmd_op == 2'd1) begin
                    n_mode = MStep; n_cause = 2'b00;
                end
            end
            MStep: begin
                n_mode = MHalt; n_cause = 2'b11;
            end
            MRun: begin
                if (clr) ;
                else if (hreq) begin n_mode = MHalt; n_cause = 2'b11; end
                else if (bp) begin n_mode = MHalt; n_cause = 2'b01; end
                else if (lim) begin n_mode = MHalt; n_cause = 2'b10; end
            end
            default: ;
        endcase
        if (clr) begin
            n_mode = MIdle; n_cnt = 0; n_cause = 2'b00;
        end
        n_done = (n_mode == MHalt) && (m_mode != MHalt);
    endtask

    task automatic run_cycle(input logic v, input logic [1:0] op);
        @(negedge clk);
        commit();
        drive(v, op);
        #1;
        evaluate();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        commit();
        drive(1'b0, 2'd0);
        #1;
        evaluate();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("rst_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        reset_model();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int k;
        logic [15:0] saved;
        reset = 1'b1;
        cfg_bp_en = 1'b0; cfg_bp_addr = 32'h0; cfg_limit = 16'd0;
        en_cnt = 0; done_cnt = 0;
        pc = 32'h0;
        drive(1'b0, 2'd0);
        reset_model();
        commit();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("reset_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("reset_cause", 32'(halt_cause), 32'd0);
        check_eq("reset_halted", 32'(halted), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Breakpoint at 0x48 with pc advancing by 4 from 0.
        cfg_bp_en = 1'b1; cfg_bp_addr = 32'h48;
        done_cnt = 0;
        run_cycle(1'b1, 2'd0);
        k = 0;
        while (!halted && k < 100) begin run_cycle(1'b0, 2'd0); k++; end
        check_eq("bp_halted", 32'(halted), 32'd1);
        check_eq("bp_cnt", 32'(cycle_cnt), 32'd18);
        check_eq("bp_cause", 32'(halt_cause), 32'd1);
        check_eq("bp_pc", pc, 32'h48);
        repeat (3) run_cycle(1'b0, 2'd0);
        check_eq("bp_done_pulses", 32'(done_cnt), 32'd1);

        // Resume retires the instruction on the breakpoint.
        run_cycle(1'b1, 2'd0);
        run_cycle(1'b0, 2'd0);
        check_eq("resume_en", 32'(cpu_en), 32'd1);
        run_cycle(1'b0, 2'd0);
        check_eq("resume_cnt", 32'(cycle_cnt), 32'd19);
        check_eq("resume_running", 32'(halted), 32'd0);
        repeat (4) run_cycle(1'b0, 2'd0);
        run_cycle(1'b1, 2'd2);
        run_cycle(1'b0, 2'd0);
        check_eq("haltcmd_cause", 32'(halt_cause), 32'd3);
        run_cycle(1'b1, 2'd3);

        // Cycle limit of 1000.
        cfg_bp_en = 1'b0; cfg_limit = 16'd1000;
        run_cycle(1'b1, 2'd0);
        k = 0;
        while (!halted && k < 1100) begin run_cycle(1'b0, 2'd0); k++; end
        check_eq("lim_halted", 32'(halted), 32'd1);
        check_eq("lim_cnt", 32'(cycle_cnt), 32'd1000);
        check_eq("lim_cause", 32'(halt_cause), 32'd2);
        run_cycle(1'b1, 2'd0);
        k = 0;
        run_cycle(1'b0, 2'd0);
        check_eq("lim_reentry_en", 32'(cpu_en), 32'd0);
        while (!halted && k < 5) begin run_cycle(1'b0, 2'd0); k++; end
        check_eq("lim_rehalt", 32'(halted), 32'd1);
        check_eq("lim_recnt", 32'(cycle_cnt), 32'd1000);
        check_eq("lim_recause", 32'(halt_cause), 32'd2);

        // Three single steps; a STEP during STEP is not accepted.
        run_cycle(1'b1, 2'd3);
        cfg_limit = 16'd0;
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 2'd1);
            run_cycle(1'b1, 2'd1);
            check_eq("step_ready", 32'(cmd_ready), 32'd0);
            check_eq("step_en", 32'(cpu_en), 32'd1);
            run_cycle(1'b0, 2'd0);
            check_eq("step_cause", 32'(halt_cause), 32'd3);
        end
        check_eq("step_retires", 32'(en_cnt), 32'd3);
        check_eq("step_cnt", 32'(cycle_cnt), 32'd3);

        // HALT command and breakpoint in the same cycle.
        run_cycle(1'b1, 2'd3);
        cfg_bp_en = 1'b1; cfg_bp_addr = n_pc + 32'd16;
        run_cycle(1'b1, 2'd0);
        k = 0;
        while (n_pc != cfg_bp_addr && k < 20) begin run_cycle(1'b0, 2'd0); k++; end
        run_cycle(1'b1, 2'd2);
        check_eq("hb_en", 32'(cpu_en), 32'd0);
        saved = cycle_cnt;
        run_cycle(1'b0, 2'd0);
        check_eq("hb_cause", 32'(halt_cause), 32'd3);
        check_eq("hb_cnt", 32'(cycle_cnt), 32'(saved));

        // CLEAR in the same cycle as a limit hit.
        run_cycle(1'b1, 2'd3);
        cfg_bp_en = 1'b0; cfg_limit = 16'd5;
        run_cycle(1'b1, 2'd0);
        k = 0;
        while (n_cnt < 5 && k < 20) begin run_cycle(1'b0, 2'd0); k++; end
        run_cycle(1'b1, 2'd3);
        check_eq("cl_en", 32'(cpu_en), 32'd0);
        run_cycle(1'b0, 2'd0);
        check_eq("cl_halted", 32'(halted), 32'd0);
        check_eq("cl_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("cl_cause", 32'(halt_cause), 32'd0);

        // Reset asserted mid-run at count 37.
        cfg_limit = 16'd0;
        run_cycle(1'b1, 2'd0);
        k = 0;
        while (n_cnt < 37 && k < 60) begin run_cycle(1'b0, 2'd0); k++; end
        check_eq("pre_reset_cnt", 32'(n_cnt), 32'd37);
        reset_mid();
        run_cycle(1'b0, 2'd0);
        check_eq("post_reset_cnt", 32'(cycle_cnt), 32'd0);
        check_eq("post_reset_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_reset_en", 32'(cpu_en), 32'd0);

        // Random commands, breakpoints and limits.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_bp_en   = 1'($urandom_range(0, 1));
                cfg_bp_addr = n_pc + 32'(4 * $urandom_range(0, 12));
                cfg_limit   = ($urandom_range(0, 2) == 0) ? 16'd0
                                                          : 16'(n_cnt + $urandom_range(0, 20));
            end
            if ($urandom_range(0, 149) == 0) reset_mid();
            else run_cycle(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
